// File: rtl/dut_emu_pkg.sv
// Shared types and constants for the DUT configuration-chain emulator.
// Latency: n/a (types, constants and a pure function); backpressure: none.
package dut_emu_pkg;

  typedef enum logic [1:0] {
    S_RESET = 2'd0,
    S_IDLE  = 2'd1,
    S_SHIFT = 2'd2
  } state_t;

  // Default chain lengths of the cfg arrays found on the real DUT.
  localparam int STATIC_0_LEN = 64;
  localparam int STATIC_1_LEN = 64;
  localparam int ARRAY_0_LEN  = 256;
  localparam int ARRAY_1_LEN  = 256;
  localparam int ARRAY_2_LEN  = 512;

  typedef struct packed {
    logic rise;
    logic fall;
  } edge_t;

  function automatic edge_t edge_detect(input logic q1, input logic q2);
    edge_t e;
    e.rise = q1 & ~q2;
    e.fall = ~q1 & q2;
    return e;
  endfunction

endpackage

// File: rtl/dut_cfg_chain_emu_if.sv
// FW-to-DUT configuration serial link: FW drives clk/data/load/reset, DUT returns chain output.
// Latency: wires only; backpressure: none.
interface dut_cfg_chain_emu_if;
  logic dut_config_clk;
  logic dut_config_in;
  logic dut_config_load;
  logic dut_reset_not;
  logic dut_config_out;

  modport master (
    output dut_config_clk,
    output dut_config_in,
    output dut_config_load,
    output dut_reset_not,
    input  dut_config_out
  );

  modport slave (
    input  dut_config_clk,
    input  dut_config_in,
    input  dut_config_load,
    input  dut_reset_not,
    output dut_config_out
  );
endinterface

// File: rtl/dut_sig_sync_edge.sv
// Two-stage sample of one FW-driven signal with rise/fall strobes taken across q1/q2.
// Latency: q1 one fw_clk edge after the port, strobes valid after that edge; backpressure: none.
module dut_sig_sync_edge
  import dut_emu_pkg::*;
#(
  parameter logic RST_VAL = 1'b0
) (
  input  logic fw_clk,
  input  logic fw_rst_n,
  input  logic d,
  output logic q1,
  output logic rise,
  output logic fall
);

  logic  q2;
  edge_t edges;

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      q1 <= RST_VAL;
      q2 <= RST_VAL;
    end else begin
      q1 <= d;
      q2 <= q1;
    end
  end

  assign edges = edge_detect(q1, q2);
  assign rise  = edges.rise;
  assign fall  = edges.fall;

endmodule

// File: rtl/dut_cfg_chain_emu.sv
// Emulated DUT config shift chain: shifts on config_clk rise, latches shadow on load fall, flags length errors.
// Latency: sr/shadow update on the 2nd fw_clk edge after a port edge; backpressure: none.
module dut_cfg_chain_emu
  import dut_emu_pkg::*;
#(
  parameter int CHAIN_LEN = 64,
  parameter int CNT_W     = 11
) (
  input  logic                 fw_clk,
  input  logic                 fw_rst_n,
  dut_cfg_chain_emu_if.slave   cfg_if,
  output logic [CHAIN_LEN-1:0] cfg_shadow,
  output logic                 cfg_shadow_valid,
  output logic [CNT_W-1:0]     shift_cnt,
  output logic                 err_overlen,
  output logic                 err_len,
  output logic                 busy
);

  localparam logic [CNT_W-1:0] LEN_C   = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic clk_q1, clk_rise, clk_fall;
  logic in_q1, in_rise, in_fall;
  logic load_q1, load_rise, load_fall;
  logic rstn_q1, rstn_rise, rstn_fall;

  dut_sig_sync_edge #(.RST_VAL(1'b0)) u_sync_clk (
    .fw_clk   (fw_clk),
    .fw_rst_n (fw_rst_n),
    .d        (cfg_if.dut_config_clk),
    .q1       (clk_q1),
    .rise     (clk_rise),
    .fall     (clk_fall)
  );

  dut_sig_sync_edge #(.RST_VAL(1'b0)) u_sync_in (
    .fw_clk   (fw_clk),
    .fw_rst_n (fw_rst_n),
    .d        (cfg_if.dut_config_in),
    .q1       (in_q1),
    .rise     (in_rise),
    .fall     (in_fall)
  );

  dut_sig_sync_edge #(.RST_VAL(1'b1)) u_sync_load (
    .fw_clk   (fw_clk),
    .fw_rst_n (fw_rst_n),
    .d        (cfg_if.dut_config_load),
    .q1       (load_q1),
    .rise     (load_rise),
    .fall     (load_fall)
  );

  dut_sig_sync_edge #(.RST_VAL(1'b1)) u_sync_rstn (
    .fw_clk   (fw_clk),
    .fw_rst_n (fw_rst_n),
    .d        (cfg_if.dut_reset_not),
    .q1       (rstn_q1),
    .rise     (rstn_rise),
    .fall     (rstn_fall)
  );

  logic unused_sync_bits;
  assign unused_sync_bits = ^{clk_q1, clk_fall, in_rise, in_fall,
                              load_q1, load_rise, rstn_rise, rstn_fall};

  logic [CHAIN_LEN-1:0] sr;
  logic [CHAIN_LEN-1:0] sr_nxt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 shift_ev;
  logic                 load_ev;
  logic                 overlen_hit;
  logic                 len_ok;
  state_t               state;
  state_t               state_nxt;

  // DUT reset masks both events so it wins over anything arriving with it.
  assign shift_ev = clk_rise & rstn_q1;
  assign load_ev  = load_fall & rstn_q1;

  // Load sees the post-shift view so a coincident shift edge is included.
  assign sr_nxt      = shift_ev ? {sr[CHAIN_LEN-2:0], in_q1} : sr;
  assign cnt_nxt     = (shift_ev && (shift_cnt != CNT_MAX)) ? shift_cnt + 1'b1 : shift_cnt;
  assign overlen_hit = shift_ev && (shift_cnt >= LEN_C);
  assign len_ok      = (cnt_nxt == LEN_C);

  assign cfg_if.dut_config_out = sr[CHAIN_LEN-1];

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      sr               <= '0;
      cfg_shadow       <= '0;
      cfg_shadow_valid <= 1'b0;
      shift_cnt        <= '0;
      err_overlen      <= 1'b0;
      err_len          <= 1'b0;
    end else if (!rstn_q1) begin
      sr               <= '0;
      cfg_shadow       <= '0;
      cfg_shadow_valid <= 1'b0;
      shift_cnt        <= '0;
      err_overlen      <= 1'b0;
      err_len          <= 1'b0;
    end else begin
      sr <= sr_nxt;
      if (overlen_hit) begin
        err_overlen <= 1'b1;
      end
      if (load_ev) begin
        cfg_shadow       <= sr_nxt;
        cfg_shadow_valid <= len_ok;
        shift_cnt        <= '0;
        if (!len_ok) begin
          err_len <= 1'b1;
        end
      end else begin
        shift_cnt <= cnt_nxt;
      end
    end
  end

  always_ff @(posedge fw_clk or negedge fw_rst_n) begin
    if (!fw_rst_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    busy      = (state == S_SHIFT);
    if (!rstn_q1) begin
      state_nxt = S_RESET;
    end else begin
      case (state)
        S_RESET: state_nxt = S_IDLE;
        S_IDLE:  if (shift_ev && !load_ev) state_nxt = S_SHIFT;
        S_SHIFT: if (load_ev) state_nxt = S_IDLE;
        default: state_nxt = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dut_cfg_chain_emu.sv
// Bench for dut_cfg_chain_emu (CHAIN_LEN=8): directed shift/load traffic with a queued scoreboard.
// A monitor watches the port edges and checks the committed state one cycle after detection.
module tb_dut_cfg_chain_emu;

  localparam int L  = 8;
  localparam int CW = 11;

  logic          fw_clk;
  logic          fw_rst_n;
  logic [L-1:0]  cfg_shadow;
  logic          cfg_shadow_valid;
  logic [CW-1:0] shift_cnt;
  logic          err_overlen;
  logic          err_len;
  logic          busy;

  int checks = 0;
  int errors = 0;

  dut_cfg_chain_emu_if cfg_if ();

  dut_cfg_chain_emu #(.CHAIN_LEN(L), .CNT_W(CW)) u_dut (
    .fw_clk           (fw_clk),
    .fw_rst_n         (fw_rst_n),
    .cfg_if           (cfg_if),
    .cfg_shadow       (cfg_shadow),
    .cfg_shadow_valid (cfg_shadow_valid),
    .shift_cnt        (shift_cnt),
    .err_overlen      (err_overlen),
    .err_len          (err_len),
    .busy             (busy)
  );

  initial fw_clk = 1'b0;
  always #5 fw_clk = ~fw_clk;

  typedef struct {
    logic          care_out;
    logic          exp_out;
    logic [CW-1:0] cnt;
    logic          ovl;
    logic          elen;
    logic          bsy;
    logic          valid;
    logic [L-1:0]  shadow;
  } sh_rec_t;

  typedef struct {
    logic [L-1:0] shadow;
    logic         valid;
    logic         elen;
    logic         ovl;
  } ld_rec_t;

  sh_rec_t sh_q[$];
  ld_rec_t ld_q[$];

  // Expected state carried between shifts (what the last load/reset left behind).
  logic [L-1:0] ctx_shadow;
  logic         ctx_valid, ctx_elen, ctx_ovl, ctx_busy;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic shift_one(input logic b, input logic care, input logic eo, input int cnt);
    sh_rec_t r;
    r.care_out = care;
    r.exp_out  = eo;
    r.cnt      = CW'(cnt);
    r.ovl      = ctx_ovl;
    r.elen     = ctx_elen;
    r.bsy      = ctx_busy;
    r.valid    = ctx_valid;
    r.shadow   = ctx_shadow;
    sh_q.push_back(r);
    @(negedge fw_clk);
    cfg_if.dut_config_clk = 1'b1;
    cfg_if.dut_config_in  = b;
    repeat (2) @(negedge fw_clk);
    cfg_if.dut_config_clk = 1'b0;
    repeat (2) @(negedge fw_clk);
  endtask

  task automatic shift_byte(input logic [7:0] v, input logic [7:0] outs, input int start);
    for (int i = 0; i < 8; i++) begin
      shift_one(v[7-i], 1'b1, outs[7-i], start + i + 1);
    end
  endtask

  task automatic do_load(input logic [L-1:0] sh, input logic vld, input logic el, input logic ov);
    ld_rec_t r;
    r.shadow = sh;
    r.valid  = vld;
    r.elen   = el;
    r.ovl    = ov;
    ld_q.push_back(r);
    @(negedge fw_clk);
    cfg_if.dut_config_load = 1'b0;
    repeat (2) @(negedge fw_clk);
    cfg_if.dut_config_load = 1'b1;
    repeat (2) @(negedge fw_clk);
  endtask

  // Shift edge and load edge presented in the same sampled cycle.
  task automatic shift_load(input logic b, input logic eo, input logic [L-1:0] sh,
                            input logic vld, input logic el, input logic ov);
    sh_rec_t s;
    ld_rec_t r;
    s.care_out = 1'b1;
    s.exp_out  = eo;
    s.cnt      = '0;
    s.ovl      = ov;
    s.elen     = el;
    s.bsy      = 1'b0;
    s.valid    = vld;
    s.shadow   = sh;
    sh_q.push_back(s);
    r.shadow = sh;
    r.valid  = vld;
    r.elen   = el;
    r.ovl    = ov;
    ld_q.push_back(r);
    @(negedge fw_clk);
    cfg_if.dut_config_clk  = 1'b1;
    cfg_if.dut_config_in   = b;
    cfg_if.dut_config_load = 1'b0;
    repeat (2) @(negedge fw_clk);
    cfg_if.dut_config_clk  = 1'b0;
    cfg_if.dut_config_load = 1'b1;
    repeat (2) @(negedge fw_clk);
  endtask

  task automatic check_quiet(input string tag);
    chk({tag, "_config_out"}, cfg_if.dut_config_out, 0);
    chk({tag, "_cfg_shadow"}, cfg_shadow, 0);
    chk({tag, "_shadow_valid"}, cfg_shadow_valid, 0);
    chk({tag, "_shift_cnt"}, shift_cnt, 0);
    chk({tag, "_err_overlen"}, err_overlen, 0);
    chk({tag, "_err_len"}, err_len, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  // Monitor: an edge seen at the port is sampled at q1, committed one edge later.
  initial begin
    logic    clk_prev, ld_prev, sh_pend, ld_pend;
    sh_rec_t srec;
    ld_rec_t lrec;
    clk_prev = 1'b0;
    ld_prev  = 1'b1;
    sh_pend  = 1'b0;
    ld_pend  = 1'b0;
    forever begin
      @(posedge fw_clk);
      #1;
      if (sh_pend) begin
        chk("shift_cnt", shift_cnt, srec.cnt);
        chk("shift_err_overlen", err_overlen, srec.ovl);
        chk("shift_err_len", err_len, srec.elen);
        chk("shift_busy", busy, srec.bsy);
        chk("shift_shadow_valid", cfg_shadow_valid, srec.valid);
        chk("shift_cfg_shadow", cfg_shadow, srec.shadow);
        sh_pend = 1'b0;
      end
      if (ld_pend) begin
        chk("load_cfg_shadow", cfg_shadow, lrec.shadow);
        chk("load_shadow_valid", cfg_shadow_valid, lrec.valid);
        chk("load_err_len", err_len, lrec.elen);
        chk("load_err_overlen", err_overlen, lrec.ovl);
        chk("load_shift_cnt", shift_cnt, 0);
        chk("load_busy", busy, 0);
        ld_pend = 1'b0;
      end
      if (fw_rst_n) begin
        if (cfg_if.dut_config_clk && !clk_prev) begin
          if (sh_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_shift: no expectation queued at %0t", $time);
          end else begin
            srec = sh_q.pop_front();
            if (srec.care_out) chk("config_out", cfg_if.dut_config_out, srec.exp_out);
            sh_pend = 1'b1;
          end
        end
        if (!cfg_if.dut_config_load && ld_prev) begin
          if (ld_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_load: no expectation queued at %0t", $time);
          end else begin
            lrec    = ld_q.pop_front();
            ld_pend = 1'b1;
          end
        end
      end
      clk_prev = cfg_if.dut_config_clk;
      ld_prev  = cfg_if.dut_config_load;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: bench did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] v, o;
    cfg_if.dut_config_clk  = 1'b0;
    cfg_if.dut_config_in   = 1'b0;
    cfg_if.dut_config_load = 1'b1;
    cfg_if.dut_reset_not   = 1'b1;
    fw_rst_n   = 1'b0;
    ctx_shadow = '0;
    ctx_valid  = 1'b0;
    ctx_elen   = 1'b0;
    ctx_ovl    = 1'b0;
    ctx_busy   = 1'b0;

    repeat (5) @(negedge fw_clk);
    check_quiet("in_reset");
    fw_rst_n = 1'b1;
    repeat (3) @(negedge fw_clk);
    check_quiet("after_reset");

    // Correct-length write of A5 into an empty chain.
    ctx_busy = 1'b1;
    shift_byte(8'hA5, 8'h00, 0);
    do_load(8'hA5, 1'b1, 1'b0, 1'b0);
    ctx_shadow = 8'hA5;
    ctx_valid  = 1'b1;

    // Readback: old content A5 leaves MSB-first while 3C goes in.
    shift_byte(8'h3C, 8'hA5, 0);
    do_load(8'h3C, 1'b1, 1'b0, 1'b0);
    ctx_shadow = 8'h3C;

    // Overlength: 9 shifts, flag on the 9th, shadow keeps the last 8 bits.
    shift_byte(8'hCA, 8'h3C, 0);
    ctx_ovl = 1'b1;
    shift_one(1'b1, 1'b1, 1'b1, 9);
    do_load(8'h95, 1'b0, 1'b1, 1'b1);
    ctx_shadow = 8'h95;
    ctx_valid  = 1'b0;
    ctx_elen   = 1'b1;

    // 8th shift coincident with load; sticky errors from above remain set.
    v = 8'h5A;
    o = 8'h95;
    for (int i = 0; i < 7; i++) begin
      shift_one(v[7-i], 1'b1, o[7-i], i + 1);
    end
    shift_load(v[0], o[0], 8'h5A, 1'b1, 1'b1, 1'b1);
    ctx_shadow = 8'h5A;
    ctx_valid  = 1'b1;

    // DUT reset mid-shift with config_clk still toggling.
    for (int i = 0; i < 4; i++) begin
      shift_one(1'b1, 1'b1, v[7-i], i + 1);
    end
    @(negedge fw_clk);
    cfg_if.dut_reset_not = 1'b0;
    repeat (3) @(negedge fw_clk);
    ctx_shadow = '0;
    ctx_valid  = 1'b0;
    ctx_elen   = 1'b0;
    ctx_ovl    = 1'b0;
    ctx_busy   = 1'b0;
    for (int i = 0; i < 3; i++) begin
      shift_one(1'b1, 1'b1, 1'b0, 0);
    end
    @(negedge fw_clk);
    cfg_if.dut_reset_not = 1'b1;
    repeat (3) @(negedge fw_clk);
    ctx_busy = 1'b1;
    shift_byte(8'hC3, 8'h00, 0);
    do_load(8'hC3, 1'b1, 1'b0, 1'b0);

    // Load with no shifts since the last load is a length error.
    do_load(8'hC3, 1'b0, 1'b1, 1'b0);

    repeat (5) @(negedge fw_clk);
    checks++;
    if (sh_q.size() != 0 || ld_q.size() != 0) begin
      errors++;
      $display("FAIL drain: shift queue %0d load queue %0d required 0 0", sh_q.size(), ld_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
